bilinear_fetch_sequencer: RTL
=============================

# bilinear_fetch_sequencer

- Drives the bilinear interpolation datapath.
- Walks a destination image in raster order and maps each destination pixel to a Q8.8 source coordinate.
- Fetches the four neighbouring source pixels through a single 1-cycle-latency read port.
- Presents I00/I10/I01/I11, alpha and beta to the interpolator under a valid/ready handshake.
- Sits between the source frame memory and the interpolator; forms the scaling front end.

## Interface
- DIM_W, 10: width of image dimensions and integer coordinate part (max dimension 2^DIM_W−1).
- ADDR_W, 20: memory address width; must be ≥ 2·DIM_W.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to begin a frame; ignored while busy.
- src_w, src_h  in  DIM_W each  source dimensions, sampled on accepted start.
- dst_w, dst_h  in  DIM_W each  destination dimensions, sampled on accepted start.
- step_x, step_y  in  16 each  source pixels per destination pixel, unsigned Q8.8, sampled on start.
- mem_rd_en  out  1  read strobe.
- mem_addr  out  ADDR_W  row-major source address, y·src_w + x, base 0.
- mem_rdata  in  8  read data, valid the cycle after mem_rd_en.
- out_valid  out  1  neighbour set valid.
- out_ready  in  1  interpolator accepts.
- I00, I10, I01, I11  out  8 each  neighbours (x0,y0), (x1,y0), (x0,y1), (x1,y1).
- alpha, beta  out  8 each  Q0.8 fractional x / y.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the final accepted pixel.

## Operation
- **Accumulators.** x_acc and y_acc are unsigned, DIM_W+8 bits, Q(DIM_W).8.
  - x_acc clears to 0 at each row start and adds step_x after each accepted pixel.
  - y_acc starts at 0 and adds step_y when a row completes.
  - Accumulator overflow wraps; it is the caller's responsibility.
- **Coordinate split.** x0 = min(x_acc[int], src_w−1); x1 = (x0 == src_w−1) ? x0 : x0+1; alpha = x_acc[7:0]. The y axis uses the same rules with src_h and beta.
- **Alpha/beta at clamped edges.** Not zeroed: with x1 == x0 the interpolator result is correct.
- **FSM states:**
  - IDLE: start with dst_w≠0 and dst_h≠0 → FETCH, busy=1. start with a zero destination dimension → done pulse next cycle, no reads, stay IDLE.
  - FETCH: 4 cycles, index k = 0..3. Asserts mem_rd_en with addresses A00, A10, A01, A11 in that order. Captures mem_rdata into the slot for k−1 when k ≥ 1. After k = 3 → LAST.
  - LAST: 1 cycle. Captures I11; no read. → EMIT.
  - EMIT: out_valid=1. On out_valid && out_ready:
    - Not last pixel: advance dx (or wrap dx and advance dy) → FETCH.
    - Last pixel (dx = dst_w−1, dy = dst_h−1): → IDLE, busy=0, done=1 for one cycle.
- **Output stability.** I00..I11, alpha and beta are registered and held stable while out_valid && !out_ready. No reads are issued in EMIT.
- **Reset behaviour.**
  - Reset values: all outputs 0, state IDLE, accumulators and counters 0.
  - Reset mid-frame aborts immediately; no done pulse.
  - In-flight read data arriving after reset is ignored.

## Timing
- Start is sampled at edge E0. mem_rd_en is high in the 4 cycles after E0. out_valid rises 6 cycles after E0.
- Throughput: 6 cycles per pixel with out_ready held high. Each stall cycle adds 1.
- Acceptance at edge En → next FETCH begins the cycle after En.
- done asserts the cycle after the final acceptance edge.
- mem_addr is driven from registered state only (no combinational path from out_ready).

## Configuration
- BILIN_PERF_EN defined:
  - Adds perf_reads (out, 32): counts mem_rd_en cycles.
  - Adds perf_stall (out, 32): counts cycles with out_valid && !out_ready.
  - Both counters clear on rst and on accepted start, and saturate at all-ones.
- Not defined: ports and logic absent; behaviour otherwise identical.

## Structure
- Shared package bilin_pkg holds:
  - FSM state enum (IDLE, FETCH, LAST, EMIT).
  - Q8.8 fraction width constant FRAC_W=8.
  - Neighbour index constants N00, N10, N01, N11.
- One sub-module, bilin_coord_gen: accumulators, dx/dy counters, clamp logic, address multiply. Its outputs are x0, x1, y0, y1, alpha, beta, last_pixel.

## Test plan
- **Identity fetch.** Memory model rdata = addr[7:0]; src 4×4, dst 2×2, step 0x0100. Expected:
  - Reads at 0, 1, 4, 5 in cycles 1–4 after E0.
  - First output: I00=0, I10=1, I01=4, I11=5, alpha=0, beta=0, out_valid at cycle 6.
- **Half-pixel step.** step_x=0x0080. Second pixel of row 0 → x0=0, alpha=0x80; addresses 0, 1, 4, 5 again.
- **Right-edge clamp.** src_w=4, step_x=0x0180, dx=2 → x_acc=0x300, x0=x1=3, alpha=0x00; A00=A10=3.
- **Backpressure.** out_ready low 5 cycles during EMIT. Expected:
  - Outputs constant and mem_rd_en=0 throughout.
  - With BILIN_PERF_EN, perf_stall=5 and perf_reads=4 after the first pixel.
- **Reset mid-FETCH.** rst at k=2 → all outputs 0 asynchronously, no done. A new start then reproduces the identity-fetch sequence exactly.
- **Zero destination.** dst_w=0 → done=1 one cycle after start, busy stays 0, no mem_rd_en.

Source files
------------

// File: rtl/bilin_pkg.sv
// Shared types and constants for the bilinear fetch sequencer.
package bilin_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LAST,
    EMIT
  } bilin_state_e;

  localparam int unsigned FRAC_W = 8;

  // Neighbour slot indices; also the fetch order k = 0..3.
  localparam logic [1:0] N00 = 2'd0;
  localparam logic [1:0] N10 = 2'd1;
  localparam logic [1:0] N01 = 2'd2;
  localparam logic [1:0] N11 = 2'd3;

endpackage

// File: rtl/bilinear_fetch_sequencer_if.sv
// Memory read port and interpolator handshake of the bilinear fetch sequencer.
interface bilinear_fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 20
) ();

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        I00;
  logic [7:0]        I10;
  logic [7:0]        I01;
  logic [7:0]        I11;
  logic [7:0]        alpha;
  logic [7:0]        beta;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rdata,
    output out_valid,
    input  out_ready,
    output I00, I10, I01, I11, alpha, beta
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rdata,
    input  out_valid,
    output out_ready,
    input  I00, I10, I01, I11, alpha, beta
  );

endinterface

// File: rtl/bilin_coord_gen.sv
// Destination raster walk: Q8.8 accumulators, dx/dy counters, edge clamp and
// row-major source address generation.
module bilin_coord_gen
  import bilin_pkg::*;
#(
  parameter int unsigned DIM_W  = 10,
  parameter int unsigned ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [DIM_W-1:0]  src_w,
  input  logic [DIM_W-1:0]  src_h,
  input  logic [DIM_W-1:0]  dst_w,
  input  logic [DIM_W-1:0]  dst_h,
  input  logic [15:0]       step_x,
  input  logic [15:0]       step_y,
  input  logic              sel_x1,
  input  logic              sel_y1,
  output logic [DIM_W-1:0]  x0,
  output logic [DIM_W-1:0]  x1,
  output logic [DIM_W-1:0]  y0,
  output logic [DIM_W-1:0]  y1,
  output logic [7:0]        alpha,
  output logic [7:0]        beta,
  output logic              last_pixel,
  output logic [ADDR_W-1:0] addr
);

  localparam int unsigned AccW  = DIM_W + FRAC_W;
  localparam int unsigned ProdW = 2 * DIM_W;

  logic [DIM_W-1:0] src_w_q, src_w_d, src_h_q, src_h_d;
  logic [DIM_W-1:0] dst_w_q, dst_w_d, dst_h_q, dst_h_d;
  logic [15:0]      step_x_q, step_x_d, step_y_q, step_y_d;
  logic [AccW-1:0]  x_acc_q, x_acc_d, y_acc_q, y_acc_d;
  logic [DIM_W-1:0] dx_q, dx_d, dy_q, dy_d;

  logic [DIM_W-1:0] x_int, y_int, src_w_m1, src_h_m1, dst_w_m1, dst_h_m1;
  logic [DIM_W-1:0] x_sel, y_sel;
  logic [ProdW-1:0] prod;

  assign src_w_m1 = src_w_q - DIM_W'(1);
  assign src_h_m1 = src_h_q - DIM_W'(1);
  assign dst_w_m1 = dst_w_q - DIM_W'(1);
  assign dst_h_m1 = dst_h_q - DIM_W'(1);

  assign x_int = x_acc_q[AccW-1:FRAC_W];
  assign y_int = y_acc_q[AccW-1:FRAC_W];

  // Clamp to the last source column/row; alpha/beta stay as-is since x1 == x0 there.
  assign x0    = (x_int > src_w_m1) ? src_w_m1 : x_int;
  assign x1    = (x0 == src_w_m1) ? x0 : x0 + DIM_W'(1);
  assign y0    = (y_int > src_h_m1) ? src_h_m1 : y_int;
  assign y1    = (y0 == src_h_m1) ? y0 : y0 + DIM_W'(1);
  assign alpha = x_acc_q[FRAC_W-1:0];
  assign beta  = y_acc_q[FRAC_W-1:0];

  assign last_pixel = (dx_q == dst_w_m1) && (dy_q == dst_h_m1);

  assign x_sel = sel_x1 ? x1 : x0;
  assign y_sel = sel_y1 ? y1 : y0;
  assign prod  = ProdW'(y_sel) * ProdW'(src_w_q);
  assign addr  = ADDR_W'(prod + ProdW'(x_sel));

  always_comb begin
    src_w_d  = src_w_q;
    src_h_d  = src_h_q;
    dst_w_d  = dst_w_q;
    dst_h_d  = dst_h_q;
    step_x_d = step_x_q;
    step_y_d = step_y_q;
    x_acc_d  = x_acc_q;
    y_acc_d  = y_acc_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    if (load) begin
      src_w_d  = src_w;
      src_h_d  = src_h;
      dst_w_d  = dst_w;
      dst_h_d  = dst_h;
      step_x_d = step_x;
      step_y_d = step_y;
      x_acc_d  = '0;
      y_acc_d  = '0;
      dx_d     = '0;
      dy_d     = '0;
    end else if (advance) begin
      if (dx_q == dst_w_m1) begin
        dx_d    = '0;
        x_acc_d = '0;
        dy_d    = dy_q + DIM_W'(1);
        y_acc_d = y_acc_q + AccW'(step_y_q);
      end else begin
        dx_d    = dx_q + DIM_W'(1);
        x_acc_d = x_acc_q + AccW'(step_x_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_w_q  <= '0;
      src_h_q  <= '0;
      dst_w_q  <= '0;
      dst_h_q  <= '0;
      step_x_q <= '0;
      step_y_q <= '0;
      x_acc_q  <= '0;
      y_acc_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
    end else begin
      src_w_q  <= src_w_d;
      src_h_q  <= src_h_d;
      dst_w_q  <= dst_w_d;
      dst_h_q  <= dst_h_d;
      step_x_q <= step_x_d;
      step_y_q <= step_y_d;
      x_acc_q  <= x_acc_d;
      y_acc_q  <= y_acc_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
    end
  end

endmodule

// File: rtl/bilinear_fetch_sequencer.sv
// Bilinear scaling front end: fetches four source neighbours per destination pixel.
// Optional perf counters (perf_reads, perf_stall) built when BILIN_PERF_EN is defined.
module bilinear_fetch_sequencer
  import bilin_pkg::*;
#(
  parameter int unsigned DIM_W  = 10,
  parameter int unsigned ADDR_W = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  bilinear_fetch_sequencer_if.master  bus,
  input  logic                        start,
  input  logic [DIM_W-1:0]            src_w,
  input  logic [DIM_W-1:0]            src_h,
  input  logic [DIM_W-1:0]            dst_w,
  input  logic [DIM_W-1:0]            dst_h,
  input  logic [15:0]                 step_x,
  input  logic [15:0]                 step_y,
  output logic                        busy,
  output logic                        done
`ifdef BILIN_PERF_EN
  ,
  output logic [31:0]                 perf_reads,
  output logic [31:0]                 perf_stall
`endif
);

  bilin_state_e state_q, state_d;
  logic [1:0]   k_q, k_d;
  logic [7:0]   nb_q [4];
  logic [7:0]   nb_d [4];
  logic [7:0]   alpha_q, alpha_d, beta_q, beta_d;
  logic         busy_q, busy_d, done_q, done_d;

  logic              start_ok, dims_ok, load, advance;
  logic [DIM_W-1:0]  cg_x0, cg_x1, cg_y0, cg_y1;
  logic [7:0]        cg_alpha, cg_beta;
  logic              cg_last;
  logic [ADDR_W-1:0] cg_addr;

  assign start_ok = (state_q == IDLE) && start;
  assign dims_ok  = (dst_w != '0) && (dst_h != '0);
  assign load     = start_ok && dims_ok;
  assign advance  = (state_q == EMIT) && bus.out_ready;

  bilin_coord_gen #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_coord_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .advance    (advance),
    .src_w      (src_w),
    .src_h      (src_h),
    .dst_w      (dst_w),
    .dst_h      (dst_h),
    .step_x     (step_x),
    .step_y     (step_y),
    .sel_x1     (k_q[0]),
    .sel_y1     (k_q[1]),
    .x0         (cg_x0),
    .x1         (cg_x1),
    .y0         (cg_y0),
    .y1         (cg_y1),
    .alpha      (cg_alpha),
    .beta       (cg_beta),
    .last_pixel (cg_last),
    .addr       (cg_addr)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    nb_d    = nb_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (dims_ok) begin
            state_d = FETCH;
            k_d     = 2'd0;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        // Read data trails the address by one cycle, so slot k-1 lands now.
        if (k_q != 2'd0) begin
          nb_d[k_q - 2'd1] = bus.mem_rdata;
        end
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = LAST;
        end
      end
      LAST: begin
        nb_d[N11] = bus.mem_rdata;
        alpha_d   = cg_alpha;
        beta_d    = cg_beta;
        state_d   = EMIT;
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (cg_last) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
            k_d     = 2'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      nb_q    <= '{default: '0};
      alpha_q <= '0;
      beta_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      nb_q    <= nb_d;
      alpha_q <= alpha_d;
      beta_q  <= beta_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.mem_rd_en = (state_q == FETCH);
  assign bus.mem_addr  = (state_q == FETCH) ? cg_addr : '0;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.I00       = nb_q[N00];
  assign bus.I10       = nb_q[N10];
  assign bus.I01       = nb_q[N01];
  assign bus.I11       = nb_q[N11];
  assign bus.alpha     = alpha_q;
  assign bus.beta      = beta_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef BILIN_PERF_EN
  logic [31:0] reads_q, reads_d, stall_q, stall_d;

  always_comb begin
    reads_d = reads_q;
    stall_d = stall_q;
    if (start_ok) begin
      reads_d = '0;
      stall_d = '0;
    end else begin
      if (bus.mem_rd_en && (reads_q != '1)) begin
        reads_d = reads_q + 32'd1;
      end
      if (bus.out_valid && !bus.out_ready && (stall_q != '1)) begin
        stall_d = stall_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reads_q <= '0;
      stall_q <= '0;
    end else begin
      reads_q <= reads_d;
      stall_q <= stall_d;
    end
  end

  assign perf_reads = reads_q;
  assign perf_stall = stall_q;
`else
  logic unused_coords;
  assign unused_coords = ^{cg_x0, cg_x1, cg_y0, cg_y1};
`endif

endmodule
